ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//   PS/2 keyboard receiver feeding the VGA game controller's key_in/key_en inputs.
//   Synchronises and filters the raw PS/2 clock and data lines, deframes 11-bit
//   frames and handles the E0 (extended) and F0 (break) prefixes.
//   Emits a one-cycle key_en strobe per key press (make code) in the VGA clock domain.
// PARAMETERS
//   FILTER_LEN      8      consecutive equal samples needed before filtered ps2_clk changes
//   TIMEOUT_CYCLES  50000  idle cycles inside a frame before abort (2 ms at 25 MHz)
// PORTS
//   iVGA_CLK   in   1  system/pixel clock (25 MHz); all logic on its rising edge
//   iRST_n     in   1  asynchronous active-low reset
//   ps2_clk    in   1  raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data   in   1  raw PS/2 data from the keyboard (asynchronous)
//   key_code   out  8  last accepted make code; held until the next accepted make code
//   key_en     out  1  one-cycle strobe: key_code/key_ext are valid this cycle
//   key_ext    out  1  1 = the make code was preceded by E0 (arrow keys: 6B/74/75/72)
//   frame_err  out  1  one-cycle strobe on a start/parity/stop error or a timeout
// BEHAVIOUR
//   Reset: key_code=8'h00, key_en=0, key_ext=0, frame_err=0, FSM=IDLE, prefix flags clear.
//     Reset is asynchronous and may arrive mid-frame: the partial frame is discarded.
//   Input path: 2-FF synchroniser on both lines, then a glitch filter on the clock line.
//     The filter counter saturates at FILTER_LEN and restarts on any mismatch.
//     A fall event is a 1->0 transition of the filtered clock; data is sampled at that event.
//   FSM (advances only on fall events, except for the timeout):
//     IDLE   : sampled data=0 -> DATA, bit count=0; sampled 1 -> stay in IDLE (no error).
//     DATA   : shift data in LSB first; after the 8th bit -> PARITY.
//     PARITY : odd parity over the 8 data bits + parity bit; store the result -> STOP.
//     STOP   : always -> IDLE. Frame is good if data=1 and parity is OK; otherwise raise
//              frame_err for one cycle and clear the E0/F0 flags.
//   Timeout: the counter clears on every fall event and in IDLE. If it reaches
//     TIMEOUT_CYCLES in any non-IDLE state -> IDLE, frame_err for one cycle, clear flags.
//   Byte handling for a good frame:
//     E0 -> set ext flag, no output.  F0 -> set brk flag, no output.
//     Other byte with brk=1 -> break code: no key_en; clear both flags.
//     Other byte with brk=0 -> make code: key_en=1, key_code=byte, key_ext=ext; clear flags.
//   Latency: key_en/frame_err are registered, asserted on the iVGA_CLK edge after the
//     cycle in which the stop-bit fall event is detected, for exactly one cycle.
//   Typematic repeats (the same make code resent while held) each produce a key_en
//     unless the feature below is enabled.
//   A bad frame between a prefix and its code discards the prefix; the next code is
//     treated as unprefixed.
//   frame_err and key_en are never asserted in the same cycle.
// CONFIGURATION
//   KEY_REPEAT_FILTER_EN defined: a held-key register {valid, ext, code} is added.
//     A make code equal to the held {ext, code} while valid=1 is suppressed (no key_en).
//     Any other make code emits key_en and replaces the held key.
//     A break code matching the held key clears valid; a non-matching break is ignored.
//     Reset clears valid.
//   Not defined: no held-key register; every make code, including repeats, emits key_en.
// TESTING
//   T1 frames E0,6B (good parity, 80 us bit period) -> exactly 1 key_en, key_code=6B, key_ext=1
//   T2 frames E0,F0,74 -> no key_en, no frame_err; a following 1C -> key_en, key_code=1C, key_ext=0
//   T3 frame 74 with wrong parity -> 1 frame_err pulse, no key_en; resend 74 -> key_en, code=74
//   T4 4 bits of a frame, then idle TIMEOUT_CYCLES+10 -> 1 frame_err, FSM IDLE; next 72 decoded OK
//   T5 ps2_clk low glitches of FILTER_LEN-2 cycles mid-frame -> no extra bit shifted; code correct
//   T6 E0,74 sent 3 times, then E0,F0,74, then E0,74 -> 4 key_en pulses without the macro,
//      2 with KEY_REPEAT_FILTER_EN; iRST_n low mid-frame -> all outputs 0, next frame decodes OK

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit deframer, E0/F0 prefix handling.
// Latency: key_en/frame_err one cycle after the stop-bit fall event (plus sync/filter delay).
// No backpressure: key_en is a one-cycle strobe; optional macro KEY_REPEAT_FILTER_EN drops typematic repeats.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_en,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          par_ok, par_nx;
  logic          ext_flag, ext_nx, brk_flag, brk_nx;
  logic [7:0]    code_nx;
  logic          key_ext_nx, en_nx, ferr_nx;
`ifdef KEY_REPEAT_FILTER_EN
  logic          held_vld, held_vld_nx, held_ext, held_ext_nx;
  logic [7:0]    held_code, held_code_nx;
  logic          held_match;
`endif

  // A fall event is the cycle in which the filtered clock flips from 1 to 0.
  assign fall    = filt_clk & ~clk_s2 & (filt_cnt == FW'(FILTER_LEN - 1));
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the clock must differ for FILTER_LEN consecutive samples to flip.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Inactivity counter inside a frame; restarted by every fall event.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                              tmo_cnt <= '0;
    else if (state == IDLE || fall || tmo_hit) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // State, frame datapath, prefix flags and registered outputs.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_ok    <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_en    <= 1'b0;
      frame_err <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= 8'h00;
`endif
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_nx;
      shift     <= shift_nx;
      par_ok    <= par_nx;
      ext_flag  <= ext_nx;
      brk_flag  <= brk_nx;
      key_code  <= code_nx;
      key_ext   <= key_ext_nx;
      key_en    <= en_nx;
      frame_err <= ferr_nx;
`ifdef KEY_REPEAT_FILTER_EN
      held_vld  <= held_vld_nx;
      held_ext  <= held_ext_nx;
      held_code <= held_code_nx;
`endif
    end
  end

  // Next-state: deframe on fall events, classify the byte in STOP.
  always_comb begin
    state_nx   = state;
    bit_nx     = bit_cnt;
    shift_nx   = shift;
    par_nx     = par_ok;
    ext_nx     = ext_flag;
    brk_nx     = brk_flag;
    code_nx    = key_code;
    key_ext_nx = key_ext;
    en_nx      = 1'b0;
    ferr_nx    = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
    held_vld_nx  = held_vld;
    held_ext_nx  = held_ext;
    held_code_nx = held_code;
    held_match   = held_vld && (held_ext == ext_flag) && (held_code == shift);
`endif
    if (tmo_hit) begin
      state_nx = IDLE;
      ferr_nx  = 1'b1;
      ext_nx   = 1'b0;
      brk_nx   = 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nx = DATA;
            bit_nx   = 3'd0;
          end
        end
        DATA: begin
          shift_nx = {dat_s2, shift[7:1]};
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = ^{shift, dat_s2};
          state_nx = STOP;
        end
        default: begin
          state_nx = IDLE;
          if (dat_s2 && par_ok) begin
            if (shift == 8'hE0) begin
              ext_nx = 1'b1;
            end else if (shift == 8'hF0) begin
              brk_nx = 1'b1;
            end else begin
              ext_nx = 1'b0;
              brk_nx = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
              if (brk_flag) begin
                if (held_match) held_vld_nx = 1'b0;
              end else if (!held_match) begin
                en_nx        = 1'b1;
                code_nx      = shift;
                key_ext_nx   = ext_flag;
                held_vld_nx  = 1'b1;
                held_ext_nx  = ext_flag;
                held_code_nx = shift;
              end
`else
              if (!brk_flag) begin
                en_nx      = 1'b1;
                code_nx    = shift;
                key_ext_nx = ext_flag;
              end
`endif
            end
          end else begin
            ferr_nx = 1'b1;
            ext_nx  = 1'b0;
            brk_nx  = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a shortened bit period and timeout.
// Counts key_en / frame_err strobe cycles and compares deltas against hand-computed values.
// Inputs are driven on the falling system-clock edge; outputs sampled there as well.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_en;
  logic       key_ext;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int en_tot = 0, fe_tot = 0, both_tot = 0;
  int en_base, fe_base;
  logic [7:0] last_code = 8'h00;
  logic       last_ext  = 1'b0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_en   (key_en),
    .key_ext  (key_ext),
    .frame_err(frame_err)
  );

  always #20 iVGA_CLK = ~iVGA_CLK;

  // Strobe monitor: counts high cycles of each strobe and latches the reported key.
  always @(negedge iVGA_CLK) begin
    if (iRST_n) begin
      if (key_en) begin
        en_tot    = en_tot + 1;
        last_code = key_code;
        last_ext  = key_ext;
      end
      if (frame_err) fe_tot = fe_tot + 1;
      if (key_en && frame_err) both_tot = both_tot + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iVGA_CLK);
  endtask

  task automatic mark();
    en_base = en_tot;
    fe_base = fe_tot;
  endtask

  // One PS/2 bit: data set while clock high, keyboard then pulls clock low.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 5 - (FL - 2));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // mode 0 good, 1 bad parity, 2 bad stop; nbits < 11 sends a truncated frame.
  task automatic send(input logic [7:0] b, input int mode, input bit glitch, input int nbits);
    logic [10:0] fr;
    fr = {(mode == 2) ? 1'b0 : 1'b1, (~^b) ^ (mode == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
    ps2_data = 1'b1;
    wait_cyc(60);
  endtask

  task automatic send_key(input logic [7:0] b);
    send(b, 0, 1'b0, 11);
  endtask

  initial begin
    int exp_t6;
    iRST_n   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    check("rst_key_code", {24'h0, key_code}, 32'h00);
    check("rst_key_en", {31'h0, key_en}, 32'h0);
    check("rst_key_ext", {31'h0, key_ext}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    iRST_n = 1'b1;
    wait_cyc(10);

    // T1: extended make code
    mark();
    send_key(8'hE0);
    send_key(8'h6B);
    check("t1_en_cnt", en_tot - en_base, 1);
    check("t1_code", {24'h0, last_code}, 32'h6B);
    check("t1_ext", {31'h0, last_ext}, 32'h1);
    check("t1_held_code", {24'h0, key_code}, 32'h6B);
    check("t1_fe_cnt", fe_tot - fe_base, 0);

    // T2: extended break, then a plain make
    mark();
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h74);
    check("t2_brk_en_cnt", en_tot - en_base, 0);
    check("t2_brk_fe_cnt", fe_tot - fe_base, 0);
    send_key(8'h1C);
    check("t2_en_cnt", en_tot - en_base, 1);
    check("t2_code", {24'h0, last_code}, 32'h1C);
    check("t2_ext", {31'h0, last_ext}, 32'h0);

    // T3: parity error, resend; stop-bit error after E0 discards the prefix
    mark();
    send(8'h74, 1, 1'b0, 11);
    check("t3_par_fe_cnt", fe_tot - fe_base, 1);
    check("t3_par_en_cnt", en_tot - en_base, 0);
    send_key(8'h74);
    check("t3_en_cnt", en_tot - en_base, 1);
    check("t3_code", {24'h0, last_code}, 32'h74);
    mark();
    send_key(8'hE0);
    send(8'h75, 2, 1'b0, 11);
    check("t3_stop_fe_cnt", fe_tot - fe_base, 1);
    send_key(8'h75);
    check("t3_noprefix_en", en_tot - en_base, 1);
    check("t3_noprefix_ext", {31'h0, last_ext}, 32'h0);

    // T4: truncated frame, timeout must fire only after the idle limit
    mark();
    send(8'h72, 0, 1'b0, 4);
    wait_cyc(250);
    check("t4_early_fe", fe_tot - fe_base, 0);
    wait_cyc(TMO + 10);
    check("t4_tmo_fe_cnt", fe_tot - fe_base, 1);
    check("t4_tmo_en_cnt", en_tot - en_base, 0);
    mark();
    send_key(8'h72);
    check("t4_next_en", en_tot - en_base, 1);
    check("t4_next_code", {24'h0, last_code}, 32'h72);

    // T5: short low glitches on ps2_clk during every high phase
    mark();
    send(8'h5A, 0, 1'b1, 11);
    check("t5_en_cnt", en_tot - en_base, 1);
    check("t5_code", {24'h0, last_code}, 32'h5A);
    check("t5_fe_cnt", fe_tot - fe_base, 0);

    // T6: typematic repeats of an extended key, release, press again
    mark();
    for (int i = 0; i < 3; i++) begin
      send_key(8'hE0);
      send_key(8'h74);
    end
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h74);
    send_key(8'hE0);
    send_key(8'h74);
`ifdef KEY_REPEAT_FILTER_EN
    exp_t6 = 2;
`else
    exp_t6 = 4;
`endif
    check("t6_en_cnt", en_tot - en_base, exp_t6);
    check("t6_code", {24'h0, last_code}, 32'h74);
    check("t6_ext", {31'h0, last_ext}, 32'h1);
    check("t6_fe_cnt", fe_tot - fe_base, 0);

    // Reset arriving mid-frame discards the partial frame
    send(8'h6B, 0, 1'b0, 5);
    iRST_n = 1'b0;
    wait_cyc(2);
    check("mid_rst_code", {24'h0, key_code}, 32'h00);
    check("mid_rst_ext", {31'h0, key_ext}, 32'h0);
    check("mid_rst_en", {31'h0, key_en}, 32'h0);
    check("mid_rst_fe", {31'h0, frame_err}, 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    iRST_n = 1'b1;
    wait_cyc(20);
    mark();
    send_key(8'h74);
    check("post_rst_en", en_tot - en_base, 1);
    check("post_rst_code", {24'h0, last_code}, 32'h74);
    check("post_rst_ext", {31'h0, last_ext}, 32'h0);
    check("post_rst_fe", fe_tot - fe_base, 0);

    check("en_fe_overlap", both_tot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
